// File: rtl/gty_quad_bringup.sv
// Power-up and reset sequencer for a four-lane GTY quad: holds the wizard in reset,
// waits for settled power-good, releases user clocks and watches for reset-done.
module gty_quad_bringup #(
    parameter int LANES        = 4,
    parameter int RESET_CYCLES = 256,
    parameter int PGOOD_SETTLE = 65536,
    parameter int DONE_TIMEOUT = 1048576
) (
    input  logic             clk_125mhz,
    input  logic             rst_n,
    input  logic             restart_req,
    input  logic [LANES-1:0] pwrgood,
    input  logic [LANES-1:0] tx_pmaresetdone,
    input  logic [LANES-1:0] rx_pmaresetdone,
    input  logic [LANES-1:0] tx_divresetdone,
    input  logic [LANES-1:0] rx_divresetdone,
    output logic             gty_reset_all,
    output logic             tx_clock_stable,
    output logic             rx_clock_stable,
    output logic             quad_ready,
    output logic [7:0]       retry_count,
    output logic [2:0]       state
);

    localparam int MAX_AB  = (RESET_CYCLES > PGOOD_SETTLE) ? RESET_CYCLES : PGOOD_SETTLE;
    localparam int MAX_ALL = (MAX_AB > DONE_TIMEOUT) ? MAX_AB : DONE_TIMEOUT;
    localparam int CW      = (MAX_ALL > 1) ? $clog2(MAX_ALL) : 1;
    localparam int SW      = 5 * LANES;

    typedef enum logic [2:0] {
        RESET_HOLD = 3'd0,
        WAIT_PGOOD = 3'd1,
        SETTLE     = 3'd2,
        WAIT_DONE  = 3'd3,
        RUN        = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      retry_q, retry_d;
    logic [SW-1:0]   meta_q, sync_q;
    logic            pg_all_s, done_all_s, fail_s;

    // Two-flop synchronizers for every asynchronous status bit
    always_ff @(posedge clk_125mhz or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= {SW{1'b0}};
            sync_q <= {SW{1'b0}};
        end else begin
            meta_q <= {pwrgood, tx_pmaresetdone, rx_pmaresetdone, tx_divresetdone, rx_divresetdone};
            sync_q <= meta_q;
        end
    end

    assign pg_all_s   = &sync_q[SW-1:4*LANES];
    assign done_all_s = &sync_q[4*LANES-1:0];

    // Next-state, shared counter and retry bookkeeping
    always_comb begin
        state_d = state_q;
        fail_s  = 1'b0;
        if (restart_req) begin
            state_d = RESET_HOLD;
        end else begin
            case (state_q)
                RESET_HOLD: begin
                    if (cnt_q == CW'(RESET_CYCLES - 1)) state_d = WAIT_PGOOD;
                    else                                state_d = RESET_HOLD;
                end
                WAIT_PGOOD: begin
                    if (pg_all_s) state_d = SETTLE;
                    else          state_d = WAIT_PGOOD;
                end
                SETTLE: begin
                    if (!pg_all_s)                           state_d = WAIT_PGOOD;
                    else if (cnt_q == CW'(PGOOD_SETTLE - 1)) state_d = WAIT_DONE;
                    else                                     state_d = SETTLE;
                end
                WAIT_DONE: begin
                    // Power loss outranks done; done outranks the timeout.
                    if (!pg_all_s) begin
                        state_d = RESET_HOLD;
                        fail_s  = 1'b1;
                    end else if (done_all_s) begin
                        state_d = RUN;
                    end else if (cnt_q == CW'(DONE_TIMEOUT - 1)) begin
                        state_d = RESET_HOLD;
                        fail_s  = 1'b1;
                    end else begin
                        state_d = WAIT_DONE;
                    end
                end
                RUN: begin
                    if (!pg_all_s) begin
                        state_d = RESET_HOLD;
                        fail_s  = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
                default: state_d = RESET_HOLD;
            endcase
        end

        if (restart_req || (state_d != state_q)) cnt_d = {CW{1'b0}};
        else                                     cnt_d = cnt_q + CW'(1);

        if (fail_s && (retry_q != 8'hFF)) retry_d = retry_q + 8'd1;
        else                              retry_d = retry_q;
    end

    // FSM state, counter and retry registers
    always_ff @(posedge clk_125mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RESET_HOLD;
            cnt_q   <= {CW{1'b0}};
            retry_q <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
        end
    end

    // Registered outputs decoded from the current state; unknown encodings look like reset
    always_ff @(posedge clk_125mhz or negedge rst_n) begin
        if (!rst_n) begin
            gty_reset_all   <= 1'b1;
            tx_clock_stable <= 1'b0;
            rx_clock_stable <= 1'b0;
            quad_ready      <= 1'b0;
            retry_count     <= 8'd0;
            state           <= 3'd0;
        end else begin
            gty_reset_all   <= (state_q != WAIT_PGOOD) && (state_q != SETTLE) &&
                               (state_q != WAIT_DONE)  && (state_q != RUN);
            tx_clock_stable <= (state_q == WAIT_DONE) || (state_q == RUN);
            rx_clock_stable <= (state_q == WAIT_DONE) || (state_q == RUN);
            quad_ready      <= (state_q == RUN);
            retry_count     <= retry_q;
            state           <= state_q;
        end
    end

endmodule
